// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port; RF_WR_SCOREBOARD_EN adds a per-register busy scoreboard.
// Latency: 1 cycle from accept to reg_write; sustains one write per cycle.
// Backpressure: req_ready is a combinational one-hot grant; ungranted requesters simply wait.
module rf_write_arbiter #(
   parameter int NREQ  = 2,
   parameter int ADDR  = 5,
   parameter int BUS_W = 32
) (
   input  logic                    reloj,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*ADDR-1:0]    req_addr,
   input  logic [NREQ*BUS_W-1:0]   req_data,
   output logic [ADDR-1:0]         rd_addr,
   output logic [BUS_W-1:0]        rd_w_data,
   output logic                    reg_write,
   input  logic                    rsv_valid,
   input  logic [ADDR-1:0]         rsv_addr,
   output logic [(1<<ADDR)-1:0]    busy
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] grant_idx;
   logic [PTR_W-1:0] ptr_nxt;
   logic             xfer;
   logic [ADDR-1:0]  sel_addr;
   logic [BUS_W-1:0] sel_data;

   // Scan from rr_ptr with wrap; the first valid requester wins.
   always_comb begin
      logic found;
      int   j;
      req_ready = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req_valid[j]) begin
            found        = 1'b1;
            req_ready[j] = 1'b1;
            grant_idx    = PTR_W'(j);
         end
      end
   end

   assign xfer     = |req_ready;
   assign sel_addr = req_addr[int'(grant_idx)*ADDR +: ADDR];
   assign sel_data = req_data[int'(grant_idx)*BUS_W +: BUS_W];
   assign ptr_nxt  = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);

   always_ff @(posedge reloj or posedge reset) begin
      if (reset) begin
         rr_ptr    <= '0;
         reg_write <= 1'b0;
         rd_addr   <= '0;
         rd_w_data <= '0;
      end else if (xfer) begin
         rr_ptr    <= ptr_nxt;
         rd_addr   <= sel_addr;
         rd_w_data <= sel_data;
         // Writes to r0 are accepted but never reach the RF.
         reg_write <= (sel_addr != '0);
      end else begin
         reg_write <= 1'b0;
      end
   end

`ifdef RF_WR_SCOREBOARD_EN
   logic [(1<<ADDR)-1:0] busy_q;

   // Clear on commit first so a same-edge reservation of that register wins.
   always_ff @(posedge reloj or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         if (reg_write)
            busy_q[rd_addr] <= 1'b0;
         if (rsv_valid && (rsv_addr != '0))
            busy_q[rsv_addr] <= 1'b1;
      end
   end

   assign busy = busy_q;
`else
   logic unused_rsv;
   assign unused_rsv = ^{rsv_valid, rsv_addr};
   assign busy       = '0;
`endif

endmodule
